// File: rtl/steer_pkg.sv
// steer_pkg
// Shared types and helpers for the proportional steering front end.
//   Q0..Q3   : quadrature states in right-going order (00, 01, 11, 10)
//   dir_e    : step request direction
//   satAdd   : signed add clamped to a signed range of a given bit width
package steer_pkg;

  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b11;
  localparam logic [1:0] Q3 = 2'b10;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2
  } dir_e;

  // Adds two signed values and clamps the result to the range of a w-bit
  // signed number. The sum is formed two bits wider so it can never wrap
  // before the clamp is applied.
  function automatic logic signed [31:0] satAdd(input logic signed [31:0] a,
                                                input logic signed [31:0] b,
                                                input int w);
    logic signed [33:0] sum;
    logic signed [33:0] maxV;
    logic signed [33:0] minV;
    sum  = 34'(a) + 34'(b);
    maxV = (34'sd1 <<< (w - 1)) - 34'sd1;
    minV = -(34'sd1 <<< (w - 1));
    if (sum > maxV) begin
      return maxV[31:0];
    end else if (sum < minV) begin
      return minV[31:0];
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/quad_phase_step.sv
// quad_phase_step
// Two-bit gray up/down counter producing a quadrature pair. A right step
// walks 00->01->11->10->00, a left step walks the reverse; exactly one bit
// changes per step and the state is held when no step is requested.
//   CLK      : clock
//   Reset_n  : asynchronous active-low reset (state returns to 00)
//   step_req : advance one phase this cycle
//   step_dir : direction of the requested phase change
//   q        : registered quadrature state
module quad_phase_step
  import steer_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       step_req,
  input  dir_e       step_dir,
  output logic [1:0] q
);

  logic [1:0] q_q;
  logic [1:0] q_d;

  // Next phase: move one position along the gray ring in the requested
  // direction; a request without a direction is treated as no request.
  always_comb begin
    q_d = q_q;
    if (step_req && (step_dir != DIR_NONE)) begin
      case (q_q)
        Q0:      q_d = (step_dir == DIR_RIGHT) ? Q1 : Q3;
        Q1:      q_d = (step_dir == DIR_RIGHT) ? Q2 : Q0;
        Q2:      q_d = (step_dir == DIR_RIGHT) ? Q3 : Q1;
        default: q_d = (step_dir == DIR_RIGHT) ? Q0 : Q2;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      q_q <= Q0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/analog_steer_quad.sv
// analog_steer_quad
// Turns an analog stick X value or relative mouse deltas into a rate-limited
// quadrature pair for the Sprint 1 steering inputs.
//   CLK          : clock shared with the core's steering sampler
//   Reset_n      : asynchronous active-low reset
//   mode         : 0 = analog rate mode, 1 = mouse relative mode
//   analog_x     : signed stick X, positive = right
//   analog_valid : when low the stick reads as centred
//   mouse_dx     : signed mouse X delta, positive = right
//   mouse_strobe : one-cycle qualifier for mouse_dx
//   steer        : quadrature pair, [1] -> SteerA_I, [0] -> SteerB_I
//   busy         : mouse steps still pending
module analog_steer_quad
  import steer_pkg::*;
#(
  parameter int CLKDIV   = 22500,
  parameter int ACC_W    = 10,
  parameter int DEADZONE = 8
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              mode,
  input  logic signed [7:0] analog_x,
  input  logic              analog_valid,
  input  logic signed [8:0] mouse_dx,
  input  logic              mouse_strobe,
  output logic [1:0]        steer,
  output logic              busy
);

  // Wide enough for the largest legal divider (2^20).
  localparam int               DIV_W    = 21;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLKDIV - 1);
  localparam logic [6:0]       DZ       = 7'(DEADZONE);

  logic [DIV_W-1:0]        divCnt_q, divCnt_d;
  logic                    mode_q;
  logic [6:0]              frac_q, frac_d;
  logic signed [ACC_W-1:0] pending_q, pending_d;
  logic                    busy_q;

  logic                    tick;
  logic                    modeSwitch;
  logic [6:0]              mag;
  logic [7:0]              fracSum;
  logic signed [31:0]      pendAdj;
  dir_e                    stepDir;
  logic                    stepReq;

  assign tick       = (divCnt_q == '0);
  assign modeSwitch = (mode != mode_q);
  assign divCnt_d   = tick ? DIV_LOAD : (divCnt_q - DIV_W'(1));

  // Stick magnitude; -128 has no positive twin in 8 bits so it saturates.
  always_comb begin
    mag = '0;
    if (analog_valid) begin
      if (analog_x == 8'sh80) begin
        mag = 7'd127;
      end else if (analog_x[7]) begin
        mag = 7'(-analog_x);
      end else begin
        mag = analog_x[6:0];
      end
    end
  end

  assign fracSum = {1'b0, frac_q} + {1'b0, mag};

  // Step generation. A mode change wipes both accumulators and suppresses
  // the step (and any strobe) for that cycle. In mouse mode the step
  // direction comes from the pre-update pending value, and the strobe delta
  // and the step's pull toward zero are folded into one saturating add.
  always_comb begin
    frac_d    = frac_q;
    pending_d = pending_q;
    stepDir   = DIR_NONE;
    pendAdj   = '0;
    if (modeSwitch) begin
      frac_d    = '0;
      pending_d = '0;
    end else if (!mode) begin
      if (tick && (mag > DZ)) begin
        frac_d = fracSum[6:0];
        if (fracSum[7]) begin
          stepDir = analog_x[7] ? DIR_LEFT : DIR_RIGHT;
        end
      end
    end else begin
      if (tick && (pending_q != '0)) begin
        stepDir = pending_q[ACC_W-1] ? DIR_LEFT : DIR_RIGHT;
        pendAdj = pending_q[ACC_W-1] ? 32'sd1 : -32'sd1;
      end
      if (mouse_strobe) begin
        pendAdj = pendAdj + 32'(mouse_dx);
      end
      pending_d = ACC_W'(satAdd(32'(pending_q), pendAdj, ACC_W));
    end
  end

  assign stepReq = (stepDir != DIR_NONE);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      divCnt_q  <= DIV_LOAD;
      mode_q    <= 1'b0;
      frac_q    <= '0;
      pending_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      divCnt_q  <= divCnt_d;
      mode_q    <= mode;
      frac_q    <= frac_d;
      pending_q <= pending_d;
      busy_q    <= (pending_d != '0);
    end
  end

  quad_phase_step u_phase (
    .CLK      (CLK),
    .Reset_n  (Reset_n),
    .step_req (stepReq),
    .step_dir (stepDir),
    .q        (steer)
  );

  assign busy = busy_q;

endmodule

// File: tb/tb_analog_steer_quad.sv
// tb_analog_steer_quad
// Drives the steering front end with directed and random stimulus and checks
// steer/busy against an integer reference model of step rate and position.
module tb_analog_steer_quad;

  localparam int CLKDIV   = 4;
  localparam int ACC_W    = 10;
  localparam int DEADZONE = 8;
  localparam int PMAX     = 511;
  localparam int PMIN     = -512;

  logic              CLK = 1'b0;
  logic              Reset_n = 1'b1;
  logic              mode = 1'b0;
  logic signed [7:0] analog_x = '0;
  logic              analog_valid = 1'b0;
  logic signed [8:0] mouse_dx = '0;
  logic              mouse_strobe = 1'b0;
  logic [1:0]        steer;
  logic              busy;

  int checks = 0;
  int errors = 0;

  // Reference model: edges since reset release, fractional rate accumulator,
  // mouse pending count, and the absolute step position (right = +1).
  int   edgeCount;
  int   mFrac;
  int   mPend;
  int   mPos;
  logic mModePrev;
  logic mBusy;

  // Observed step counts derived from consecutive steer samples.
  int obsRight;
  int obsLeft;
  int prevIdx;

  always #5 CLK = ~CLK;

  analog_steer_quad #(
    .CLKDIV   (CLKDIV),
    .ACC_W    (ACC_W),
    .DEADZONE (DEADZONE)
  ) dut (
    .CLK          (CLK),
    .Reset_n      (Reset_n),
    .mode         (mode),
    .analog_x     (analog_x),
    .analog_valid (analog_valid),
    .mouse_dx     (mouse_dx),
    .mouse_strobe (mouse_strobe),
    .steer        (steer),
    .busy         (busy)
  );

  // Position on the right-going ring 00,01,11,10 for a step count.
  function automatic logic [1:0] posToSteer(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int idxOf(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Advances the reference model by one clock edge using the inputs that
  // were present during the cycle just ended. Every CLKDIV-th edge after
  // release ends a step slot.
  task automatic modelEdge();
    bit tick;
    int ax, mag, s, dirv, np;
    edgeCount++;
    tick = ((edgeCount % CLKDIV) == 0);
    if (mode != mModePrev) begin
      mFrac = 0;
      mPend = 0;
    end else if (!mode) begin
      ax  = int'(analog_x);
      mag = analog_valid ? ((ax < 0) ? -ax : ax) : 0;
      if (mag > 127) mag = 127;
      if (tick && mag > DEADZONE) begin
        s = mFrac + mag;
        if (s >= 128) mPos += (ax > 0) ? 1 : -1;
        mFrac = s % 128;
      end
    end else begin
      dirv = (tick && mPend != 0) ? ((mPend > 0) ? 1 : -1) : 0;
      np   = mPend + (mouse_strobe ? int'(mouse_dx) : 0) - dirv;
      if (np > PMAX) np = PMAX;
      if (np < PMIN) np = PMIN;
      mPend = np;
      mPos += dirv;
    end
    mModePrev = mode;
    mBusy     = (mPend != 0);
  endtask

  // One clock: model update at the edge, then settle before sampling.
  task automatic stepClock();
    @(posedge CLK);
    modelEdge();
    #1;
  endtask

  task automatic stepAndTrack();
    int nowIdx, d;
    stepClock();
    nowIdx = idxOf(steer);
    d = (nowIdx - prevIdx + 4) % 4;
    if (d == 1) obsRight++;
    if (d == 3) obsLeft++;
    prevIdx = nowIdx;
  endtask

  // Releases reset away from the active edge and restarts the model.
  task automatic releaseReset();
    mode = 1'b0; analog_x = '0; analog_valid = 1'b0;
    mouse_dx = '0; mouse_strobe = 1'b0;
    @(negedge CLK);
    Reset_n   = 1'b1;
    edgeCount = 0; mFrac = 0; mPend = 0; mPos = 0;
    mModePrev = 1'b0; mBusy = 1'b0;
    obsRight = 0; obsLeft = 0; prevIdx = 0;
  endtask

  task automatic doReset();
    @(posedge CLK);
    #1 Reset_n = 1'b0;
    @(posedge CLK);
    #1;
    releaseReset();
  endtask

  // Reset hold with random inputs, the quiet first slot after release, and
  // an asynchronous reset landing mid-slot.
  task automatic test_reset();
    @(posedge CLK);
    #1 Reset_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mode         = 1'($urandom_range(0, 1));
      analog_x     = 8'($urandom);
      analog_valid = 1'($urandom_range(0, 1));
      mouse_dx     = 9'($urandom);
      mouse_strobe = 1'($urandom_range(0, 1));
      @(posedge CLK);
      #1;
      checks++;
      if (steer !== 2'b00 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold: steer=%b busy=%b, expected 00/0", steer, busy);
      end
    end
    releaseReset();
    mode = 1'b0; analog_x = 8'sd127; analog_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      stepClock();
      checks++;
      if (steer !== posToSteer(mPos)) begin
        errors++;
        $display("[TB] FAIL reset_release steer edge %0d: got %b expected %b", edgeCount, steer, posToSteer(mPos));
      end
      if (i < CLKDIV) begin
        checks++;
        if (steer !== 2'b00) begin
          errors++;
          $display("[TB] FAIL reset_first_slot edge %0d: got %b expected 00", edgeCount, steer);
        end
      end
    end
    Reset_n = 1'b0;
    #1;
    checks++;
    if (steer !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async: steer=%b busy=%b, expected 00/0", steer, busy);
    end
    releaseReset();
    mode = 1'b0; analog_x = 8'sd127; analog_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      stepClock();
      checks++;
      if (steer !== posToSteer(mPos)) begin
        errors++;
        $display("[TB] FAIL reset_restart steer edge %0d: got %b expected %b", edgeCount, steer, posToSteer(mPos));
      end
    end
  endtask

  // Full right, deadzone edge, invalid stick, and half-rate left.
  task automatic test_analog_patterns();
    int axTab [4];
    int vTab  [4];
    int nTab  [4];
    int rTab  [4];
    int lTab  [4];
    axTab = '{127, 8, -128, -64};
    vTab  = '{1, 1, 0, 1};
    nTab  = '{512, 400, 400, 400};
    rTab  = '{127, 0, 0, 0};
    lTab  = '{0, 0, 0, 50};
    for (int p = 0; p < 4; p++) begin
      int lastEdge, total;
      doReset();
      mode = 1'b0; analog_x = 8'(axTab[p]); analog_valid = 1'(vTab[p]);
      lastEdge = -100;
      total = 0;
      for (int i = 0; i < nTab[p]; i++) begin
        stepAndTrack();
        checks++;
        if (steer !== posToSteer(mPos) || busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL analog_%0d edge %0d: steer=%b busy=%b expected %b/0", axTab[p], edgeCount, steer, busy, posToSteer(mPos));
        end
        if (obsRight + obsLeft != total) begin
          checks++;
          if (edgeCount - lastEdge < CLKDIV) begin
            errors++;
            $display("[TB] FAIL analog_spacing edge %0d: gap %0d expected >= %0d", edgeCount, edgeCount - lastEdge, CLKDIV);
          end
          lastEdge = edgeCount;
          total = obsRight + obsLeft;
        end
      end
      checks++;
      if (obsRight != rTab[p] || obsLeft != lTab[p]) begin
        errors++;
        $display("[TB] FAIL analog_%0d_count: right=%0d left=%0d expected %0d/%0d", axTab[p], obsRight, obsLeft, rTab[p], lTab[p]);
      end
    end
  endtask

  // One +5 strobe gives five right steps, one per slot.
  task automatic test_mouse_burst();
    doReset();
    mode = 1'b1;
    for (int i = 0; i < 4; i++) stepAndTrack();
    mouse_dx = 9'sd5; mouse_strobe = 1'b1;
    stepAndTrack();
    mouse_strobe = 1'b0; mouse_dx = '0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL burst_busy_start: busy=%b expected 1", busy);
    end
    for (int i = 0; i < 30; i++) begin
      stepAndTrack();
      checks++;
      if (steer !== posToSteer(mPos) || busy !== mBusy) begin
        errors++;
        $display("[TB] FAIL burst edge %0d: steer=%b busy=%b expected %b/%b", edgeCount, steer, busy, posToSteer(mPos), mBusy);
      end
    end
    checks++;
    if (obsRight != 5 || obsLeft != 0 || steer !== 2'b01 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL burst_total: right=%0d left=%0d steer=%b busy=%b expected 5/0/01/0", obsRight, obsLeft, steer, busy);
    end
  endtask

  // Ten +255 strobes saturate at 511; two slots fall inside the burst.
  task automatic test_mouse_saturation();
    doReset();
    mode = 1'b1;
    for (int i = 0; i < 4; i++) stepAndTrack();
    mouse_dx = 9'sd255; mouse_strobe = 1'b1;
    for (int i = 0; i < 10; i++) stepAndTrack();
    mouse_strobe = 1'b0; mouse_dx = '0;
    for (int i = 0; i < 2100; i++) begin
      stepAndTrack();
      checks++;
      if (steer !== posToSteer(mPos) || busy !== mBusy) begin
        errors++;
        $display("[TB] FAIL saturation edge %0d: steer=%b busy=%b expected %b/%b", edgeCount, steer, busy, posToSteer(mPos), mBusy);
      end
    end
    checks++;
    if (obsRight != 513 || obsLeft != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL saturation_total: right=%0d left=%0d busy=%b expected 513/0/0", obsRight, obsLeft, busy);
    end
  endtask

  // Pending 2 plus a -3 strobe on a slot: one right step, then two left.
  task automatic test_coincidence();
    doReset();
    mode = 1'b1;
    for (int i = 0; i < 4; i++) stepAndTrack();
    mouse_dx = 9'sd2; mouse_strobe = 1'b1;
    stepAndTrack();
    mouse_strobe = 1'b0;
    stepAndTrack();
    stepAndTrack();
    mouse_dx = -9'sd3; mouse_strobe = 1'b1;
    stepAndTrack();
    mouse_strobe = 1'b0; mouse_dx = '0;
    checks++;
    if (steer !== 2'b01 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL coincide_slot: steer=%b busy=%b expected 01/1", steer, busy);
    end
    for (int i = 0; i < 16; i++) begin
      stepAndTrack();
      checks++;
      if (steer !== posToSteer(mPos) || busy !== mBusy) begin
        errors++;
        $display("[TB] FAIL coincide edge %0d: steer=%b busy=%b expected %b/%b", edgeCount, steer, busy, posToSteer(mPos), mBusy);
      end
    end
    checks++;
    if (obsRight != 1 || obsLeft != 2 || steer !== 2'b10 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL coincide_total: right=%0d left=%0d steer=%b busy=%b expected 1/2/10/0", obsRight, obsLeft, steer, busy);
    end
  endtask

  // Leaving mouse mode mid-burst discards the remaining steps.
  task automatic test_mode_switch();
    doReset();
    mode = 1'b1;
    for (int i = 0; i < 4; i++) stepAndTrack();
    mouse_dx = 9'sd20; mouse_strobe = 1'b1;
    stepAndTrack();
    mouse_strobe = 1'b0; mouse_dx = '0;
    for (int i = 0; i < 5; i++) stepAndTrack();
    mode = 1'b0; analog_x = '0; analog_valid = 1'b1;
    stepAndTrack();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL switch_clear: busy=%b expected 0", busy);
    end
    for (int i = 0; i < 40; i++) begin
      stepAndTrack();
      checks++;
      if (steer !== posToSteer(mPos) || busy !== mBusy) begin
        errors++;
        $display("[TB] FAIL switch edge %0d: steer=%b busy=%b expected %b/%b", edgeCount, steer, busy, posToSteer(mPos), mBusy);
      end
    end
    checks++;
    if (obsRight != 1 || obsLeft != 0 || steer !== 2'b01) begin
      errors++;
      $display("[TB] FAIL switch_total: right=%0d left=%0d steer=%b expected 1/0/01", obsRight, obsLeft, steer);
    end
  endtask

  // Random mode flips, stick values and mouse strobes against the model.
  task automatic test_random();
    doReset();
    mode = 1'($urandom_range(0, 1));
    analog_x = 8'($urandom); analog_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) mode = ~mode;
      if ($urandom_range(0, 49) == 0) begin
        analog_x     = 8'($urandom);
        analog_valid = ($urandom_range(0, 7) != 0);
      end
      mouse_strobe = ($urandom_range(0, 15) == 0);
      mouse_dx     = 9'($urandom);
      stepClock();
      checks++;
      if (steer !== posToSteer(mPos) || busy !== mBusy) begin
        errors++;
        $display("[TB] FAIL random edge %0d: steer=%b busy=%b expected %b/%b", edgeCount, steer, busy, posToSteer(mPos), mBusy);
      end
    end
    mouse_strobe = 1'b0;
  endtask

  initial begin
    test_reset();
    test_analog_patterns();
    test_mouse_burst();
    test_mouse_saturation();
    test_coincidence();
    test_mode_switch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/analog_steer_quad.md
# analog_steer_quad

Converts proportional steering input (analog stick X or relative mouse delta) into the two-phase quadrature pair consumed by the Sprint 1 core's SteerA_I/SteerB_I inputs. It sits between hps_io joystick/mouse outputs and the sprint1 core, as a proportional alternative to the digital left/right steering path. Step rate is bounded by a clock divider so the core's steering sampler never misses a phase.

## Interface
Parameters:
- CLKDIV, 22500: clocks per step slot; at most one quadrature phase change per slot. Legal range 2..2^20.
- ACC_W, 10: width of the signed mouse-pending accumulator.
- DEADZONE, 8: analog magnitude at or below which no steps are produced.

Ports:
- CLK  in  1  single clock; the same clock that feeds the core's steering sampler.
- Reset_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = analog rate mode, 1 = mouse relative mode.
- analog_x  in  8  signed stick X, -128..127; positive = right.
- analog_valid  in  1  when low, analog_x is treated as 0.
- mouse_dx  in  9  signed mouse X delta; positive = right.
- mouse_strobe  in  1  one-cycle pulse qualifying mouse_dx.
- steer  out  2  quadrature pair; [1] drives SteerA_I and [0] drives SteerB_I.
- busy  out  1  high while the mouse-pending accumulator is nonzero.

## Operation
Divider:
- Counts down from CLKDIV-1 to 0 and reloads.
- `tick` is asserted in the cycle the count is 0.

Analog mode (mode = 0):
- mag = |analog_x|, with -128 saturated to 127; mag = 0 if analog_valid is low.
- On tick with mag > DEADZONE: frac (7-bit unsigned) <= frac + mag. A carry out of bit 6 requests one step, direction = sign of analog_x.
- On tick with mag <= DEADZONE: frac is held.

Mouse mode (mode = 1):
- On mouse_strobe: pending <= sat(pending + sext(mouse_dx)). Saturate to the signed ACC_W range; never wrap.
- On tick with pending ≠ 0: request one step toward zero (right if pending > 0, left if < 0) and move pending one toward 0.
- Strobe and tick in the same cycle: pending <= sat(pending + dx − dir), where dir is computed from the pre-update pending value.

Mode switch:
- The registered mode differs from the input mode for one cycle; in that cycle frac and pending clear to 0 and no step is issued.

Quadrature phase machine (2-bit state Q, steer = Q):
- Right step: 00→01→11→10→00.
- Left step: the reverse sequence.
- No request: Q is held.
- Exactly one bit of steer changes per step. steer never skips a state.

busy = (pending ≠ 0), registered.

## Timing
- Reset (asynchronous, while Reset_n is low): steer = 00, busy = 0, divider = CLKDIV-1, frac = 0, pending = 0, registered mode = 0.
- Step latency: steer updates on the clock edge ending the tick cycle (1 cycle). No combinational path from any input to steer.
- Minimum spacing between steer edges is CLKDIV clocks. Maximum analog rate is 127/128 steps per slot.
- busy updates on the same edge as pending.
- mouse_strobe is honoured in every cycle, including tick and mode-switch cycles. In a mode-switch cycle the clear wins and the strobe is dropped.
- Reset_n asserted mid-slot aborts the slot immediately. After release, the first tick occurs CLKDIV clocks later.

## Structure
- Package steer_pkg:
  - Quadrature state constants Q0..Q3 = 00/01/11/10.
  - Direction enum {DIR_NONE, DIR_RIGHT, DIR_LEFT}.
  - Saturating signed add function parameterised on width.
- Sub-module quad_phase_step: CLK, Reset_n, step_req, step_dir → 2-bit Q. It is a pure gray up/down counter, reused by any future spinner/steering front end.
- The top level holds the divider, the analog fractional accumulator, the mouse accumulator and the mode-switch clear.

## Test plan
All scenarios use CLKDIV = 4.
- Reset: hold Reset_n low with random inputs → steer = 00 and busy = 0 throughout. After release, no steer change for ≥4 clocks.
- Analog full right: mode 0, analog_x = 127, valid = 1 for 512 clocks → steer cycles 00,01,11,10. Each edge is 4 clocks apart. 127 steps ±1 per 128 ticks.
- Analog deadzone and valid: analog_x = 8 gives 0 steps over 400 clocks; analog_x = -128 with valid = 0 gives 0 steps; analog_x = -64 gives the left sequence 00→10→11→01 at 1 step per 2 ticks.
- Mouse burst: mode 1, one strobe with dx = +5 → exactly 5 right steps, one per tick. busy is high from the strobe until the edge of the 5th step, then 00-relative phase equals 01.
- Mouse saturation and coincidence: with ACC_W = 10, 10 strobes of dx = +255 → pending saturates at 511, no wrap. A strobe of dx = -3 landing on a tick while pending = 2 → pending = 2 − 3 − 1 = −2, followed by 2 left steps.
- Mode switch mid-burst: pending = 20, flip mode to 0 with analog_x = 0 → pending and busy clear within 1 cycle and no further steps occur.
